// File: rtl/memory_reg.sv
// Execute-to-memory pipeline register: captures address, store data, PC and load/store info.
// Define MISALIGN_CHECK_EN to flag misaligned half/word accesses and squash their side effects.
module memory_reg #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     regE_alu_result_i,
  input  logic [7:0]           regE_load_store_info_i,
  input  logic [WIDTH-1:0]     regE_write_data_i,
  input  logic [REG_WIDTH-1:0] regE_rd_i,
  input  logic                 regE_reg_write_en_i,
  input  logic [WIDTH-1:0]     regE_pc_i,
  input  logic                 regE_valid_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [WIDTH-1:0]     regM_mem_addr_o,
  output logic [WIDTH-1:0]     regM_write_data_o,
  output logic [WIDTH-1:0]     regM_pc_o,
  output logic [7:0]           regM_load_store_info_o,
  output logic [REG_WIDTH-1:0] regM_rd_o,
  output logic                 regM_reg_write_en_o,
  output logic                 regM_valid_o,
  output logic                 regM_misalign_o
);

  typedef struct packed {
    logic [WIDTH-1:0]     addr;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     pc;
    logic [7:0]           info;
    logic [REG_WIDTH-1:0] rd;
    logic                 wen;
    logic                 valid;
    logic                 misalign;
  } stage_t;

  stage_t cur, nxt;
  logic   onehot, is_store, misal;

  // info bits: 7 lb, 6 lh, 5 lw, 4 lbu, 3 lhu, 2 sb, 1 sh, 0 sw
  assign onehot   = (regE_load_store_info_i != 8'd0) &&
                    ((regE_load_store_info_i & (regE_load_store_info_i - 8'd1)) == 8'd0);
  assign is_store = |regE_load_store_info_i[2:0];

`ifdef MISALIGN_CHECK_EN
  assign misal = onehot &&
    (((regE_load_store_info_i[6] | regE_load_store_info_i[3] | regE_load_store_info_i[1]) &&
      regE_alu_result_i[0]) ||
     ((regE_load_store_info_i[5] | regE_load_store_info_i[0]) &&
      (regE_alu_result_i[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    nxt = '0;
    if (regE_valid_i) begin
      nxt.addr     = regE_alu_result_i;
      nxt.wdata    = regE_write_data_i;
      nxt.pc       = regE_pc_i;
      nxt.rd       = regE_rd_i;
      nxt.valid    = 1'b1;
      nxt.misalign = misal;
      // A zero info byte is a non-memory op and passes through untouched
      nxt.info     = ((regE_load_store_info_i == 8'd0 || onehot) && !misal) ?
                     regE_load_store_info_i : 8'd0;
      nxt.wen      = regE_reg_write_en_i && (regE_rd_i != '0) && !is_store && !misal &&
                     (regE_load_store_info_i == 8'd0 || onehot);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           cur <= '0;
    else if (flush_i)  cur <= '0;
    else if (!stall_i) cur <= nxt;
  end

  assign regM_mem_addr_o        = cur.addr;
  assign regM_write_data_o      = cur.wdata;
  assign regM_pc_o              = cur.pc;
  assign regM_load_store_info_o = cur.info;
  assign regM_rd_o              = cur.rd;
  assign regM_reg_write_en_o    = cur.wen;
  assign regM_valid_o           = cur.valid;
  assign regM_misalign_o        = cur.misalign;

endmodule
